// File: rtl/round_timer_ctrl_pkg.sv
// Shared types for the round timer: controller states, BCD digits and counter ops.
// PRESET_DEFAULT is the power-on preset as {tens,ones} BCD digits.
package round_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0][3:0] bcd2_t;  // [1] tens, [0] ones

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_INC  = 2'd2,
    CNT_DEC  = 2'd3
  } cnt_op_e;

  localparam logic [7:0] PRESET_DEFAULT = 8'h15;

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Key/tick inputs and display/status outputs of the round timer.
interface round_timer_ctrl_if;
  import round_timer_ctrl_pkg::*;

  logic tick;
  logic key_start;
  logic key_pause;
  logic key_clear;
  logic key_inc;
  bcd_t TimeH;
  bcd_t TimeL;
  logic running;
  logic beep;
  logic done;

  modport master (
    output tick, key_start, key_pause, key_clear, key_inc,
    input  TimeH, TimeL, running, beep, done
  );

  modport slave (
    input  tick, key_start, key_pause, key_clear, key_inc,
    output TimeH, TimeL, running, beep, done
  );
endinterface

// File: rtl/round_timer_ctrl_bcd2_counter.sv
// Two-digit BCD register with load/inc/dec/hold. Increment wraps 99->00,
// decrement saturates at 00. The next value is exported so the owner can register it.
module bcd2_counter
  import round_timer_ctrl_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic    clock_1,
  input  logic    reset,
  input  cnt_op_e op,
  input  bcd2_t   load_val,
  output bcd2_t   val_q,
  output bcd2_t   val_d
);

  always_comb begin
    val_d = val_q;
    case (op)
      CNT_LOAD: val_d = load_val;
      CNT_INC: begin
        if (val_q[0] == 4'd9) begin
          val_d[0] = 4'd0;
          val_d[1] = (val_q[1] == 4'd9) ? 4'd0 : val_q[1] + 4'd1;
        end else begin
          val_d[0] = val_q[0] + 4'd1;
        end
      end
      CNT_DEC: begin
        if (val_q != '0) begin
          if (val_q[0] == 4'd0) begin
            val_d[0] = 4'd9;
            val_d[1] = val_q[1] - 4'd1;
          end else begin
            val_d[0] = val_q[0] - 4'd1;
          end
        end
      end
      default: val_d = val_q;
    endcase
  end

  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) val_q <= RST_VAL;
    else        val_q <= val_d;
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// Countdown round timer: BCD preset edited in IDLE, counted down on ticks in RUN,
// holdable in PAUSE, and an ALARM window of ALARM_TICKS ticks after expiry.
module round_timer_ctrl #(
  parameter logic [7:0]  PRESET_DEFAULT = round_timer_ctrl_pkg::PRESET_DEFAULT,
  parameter int unsigned ALARM_TICKS    = 3
) (
  input  logic clock_1,
  input  logic reset,
  round_timer_ctrl_if.slave bus
);
  import round_timer_ctrl_pkg::*;

  localparam bcd_t  ALARM_INIT = 4'(ALARM_TICKS);
  localparam bcd2_t CNT_ONE    = 8'h01;

  state_e  state_q, state_d;
  bcd_t    alarm_q, alarm_d;
  cnt_op_e pre_op, cnt_op;
  bcd2_t   pre_q, pre_d, cnt_q, cnt_d;
  bcd2_t   disp_q, disp_d;
  logic    running_q, running_d, beep_q, beep_d, done_q, done_d;

  bcd2_counter #(.RST_VAL(PRESET_DEFAULT)) u_preset (
    .clock_1(clock_1), .reset(reset), .op(pre_op), .load_val('0),
    .val_q(pre_q), .val_d(pre_d)
  );

  bcd2_counter #(.RST_VAL(PRESET_DEFAULT)) u_count (
    .clock_1(clock_1), .reset(reset), .op(cnt_op), .load_val(pre_q),
    .val_q(cnt_q), .val_d(cnt_d)
  );

  always_comb begin
    state_d = state_q;
    alarm_d = alarm_q;
    pre_op  = CNT_HOLD;
    cnt_op  = CNT_HOLD;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_inc) pre_op = CNT_INC;
        if (bus.key_start && pre_q != '0) begin
          cnt_op  = CNT_LOAD;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.key_clear) begin
          state_d = ST_IDLE;
        end else if (bus.tick) begin
          cnt_op = CNT_DEC;
          // expiry outranks a pause arriving on the same cycle
          if (cnt_q == CNT_ONE) begin
            state_d = ST_ALARM;
            alarm_d = ALARM_INIT;
            done_d  = 1'b1;
          end else if (bus.key_pause) begin
            state_d = ST_PAUSE;
          end
        end else if (bus.key_pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (bus.key_clear)      state_d = ST_IDLE;
        else if (bus.key_start) state_d = ST_RUN;
      end
      ST_ALARM: begin
        if (bus.key_clear) begin
          state_d = ST_IDLE;
          alarm_d = '0;
        end else if (bus.tick) begin
          alarm_d = alarm_q - 4'd1;
          if (alarm_q == 4'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    disp_d = pre_d;
    case (state_d)
      ST_RUN, ST_PAUSE: disp_d = cnt_d;
      ST_ALARM:         disp_d = '0;
      default:          disp_d = pre_d;
    endcase
    running_d = (state_d == ST_RUN);
    beep_d    = (state_d == ST_ALARM);
  end

  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      alarm_q   <= '0;
      disp_q    <= PRESET_DEFAULT;
      running_q <= 1'b0;
      beep_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      beep_q    <= beep_d;
      done_q    <= done_d;
    end
  end

  assign bus.TimeH   = disp_q[1];
  assign bus.TimeL   = disp_q[0];
  assign bus.running = running_q;
  assign bus.beep    = beep_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl: a decimal mode/number model compared every
// cycle, plus literal checks at the scenario points.
module tb_round_timer_ctrl;

  logic clock_1 = 1'b0;
  logic reset   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   done_seen = 0;

  round_timer_ctrl_if bus();

  round_timer_ctrl #(.PRESET_DEFAULT(8'h15), .ALARM_TICKS(3)) dut (
    .clock_1(clock_1), .reset(reset), .bus(bus)
  );

  always #5 clock_1 = ~clock_1;

  // model: plain decimal numbers and a mode code
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  int m_mode = M_IDLE, m_pre = 15, m_cnt = 15, m_alm = 0;
  bit m_done = 0;

  always @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_pre = 15; m_cnt = 15; m_alm = 0; m_done = 0;
    end else begin
      int old_pre;
      old_pre = m_pre;
      m_done  = 0;
      case (m_mode)
        M_IDLE: begin
          if (bus.key_inc) m_pre = (m_pre + 1) % 100;
          if (bus.key_start && old_pre != 0) begin m_cnt = old_pre; m_mode = M_RUN; end
        end
        M_RUN: begin
          if (bus.key_clear) m_mode = M_IDLE;
          else begin
            if (bus.tick) begin
              if (m_cnt == 1) begin m_cnt = 0; m_mode = M_ALARM; m_alm = 3; m_done = 1; end
              else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
            if (bus.key_pause && m_mode == M_RUN) m_mode = M_PAUSE;
          end
        end
        M_PAUSE: begin
          if (bus.key_clear) m_mode = M_IDLE;
          else if (bus.key_start) m_mode = M_RUN;
        end
        default: begin
          if (bus.key_clear) m_mode = M_IDLE;
          else if (bus.tick) begin
            m_alm = m_alm - 1;
            if (m_alm == 0) m_mode = M_IDLE;
          end
        end
      endcase
    end
  end

  function automatic int m_disp();
    if (m_mode == M_IDLE) return m_pre;
    if (m_mode == M_ALARM) return 0;
    return m_cnt;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock_1) begin
    chk("m_TimeH", 8'(bus.TimeH), 8'(m_disp() / 10));
    chk("m_TimeL", 8'(bus.TimeL), 8'(m_disp() % 10));
    chk("m_running", 8'(bus.running), 8'(m_mode == M_RUN));
    chk("m_beep", 8'(bus.beep), 8'(m_mode == M_ALARM));
    chk("m_done", 8'(bus.done), 8'(m_done));
    chk("bcd_range", 8'(bus.TimeH <= 4'd9 && bus.TimeL <= 4'd9), 8'd1);
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic cyc(input logic t = 0, input logic s = 0, input logic p = 0,
                     input logic c = 0, input logic i = 0);
    bus.tick = t; bus.key_start = s; bus.key_pause = p; bus.key_clear = c; bus.key_inc = i;
    @(negedge clock_1);
    bus.tick = 0; bus.key_start = 0; bus.key_pause = 0; bus.key_clear = 0; bus.key_inc = 0;
  endtask

  task automatic lit(input string nm, input int v, input logic run, input logic bp);
    chk({nm, "_h"}, 8'(bus.TimeH), 8'(v / 10));
    chk({nm, "_l"}, 8'(bus.TimeL), 8'(v % 10));
    chk({nm, "_run"}, 8'(bus.running), 8'(run));
    chk({nm, "_beep"}, 8'(bus.beep), 8'(bp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.tick = 0; bus.key_start = 0; bus.key_pause = 0; bus.key_clear = 0; bus.key_inc = 0;
    repeat (3) @(negedge clock_1);
    lit("reset", 15, 0, 0);
    chk("reset_done", 8'(bus.done), 8'd0);
    reset = 1'b1;
    @(negedge clock_1);

    // full countdown from 15, then a 3-tick alarm with idle gaps between ticks
    cyc(.s(1));
    lit("start15", 15, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      cyc(.t(1));
      lit("cd", 15 - k, k < 15, k == 15);
      if (k < 15) cyc();
    end
    chk("expire_done", 8'(bus.done), 8'd1);
    cyc();
    chk("done_one_cycle", 8'(bus.done), 8'd0);
    cyc(.t(1)); lit("alarm_t1", 0, 0, 1);
    cyc();
    cyc(.t(1)); lit("alarm_t2", 0, 0, 1);
    cyc(.t(1)); lit("alarm_t3", 15, 0, 0);
    chk("done_count", 8'(done_seen), 8'd1);

    // preset wrap 98 -> 99 -> 00, start at 00 ignored
    repeat (83) cyc(.i(1));
    lit("pre98", 98, 0, 0);
    cyc(.i(1)); lit("pre99", 99, 0, 0);
    cyc(.i(1)); lit("pre00", 0, 0, 0);
    cyc(.s(1)); lit("start00", 0, 0, 0);
    cyc();      lit("start00_b", 0, 0, 0);

    // pause holds through ticks, resume continues
    repeat (7) cyc(.i(1));
    cyc(.s(1));              lit("run07", 7, 1, 0);
    cyc(.s(1), .i(1));       lit("run_keys_ignored", 7, 1, 0);
    cyc(.p(1));              lit("pause07", 7, 0, 0);
    repeat (5) cyc(.t(1));   lit("pause_hold", 7, 0, 0);
    cyc(.i(1));              lit("pause_inc", 7, 0, 0);
    cyc(.s(1));              lit("resume", 7, 1, 0);
    cyc(.t(1));              lit("tick06", 6, 1, 0);

    // expiry beats pause; clear beats tick in alarm
    repeat (5) cyc(.t(1));   lit("at01", 1, 1, 0);
    cyc(.t(1), .p(1));       lit("exp_pause", 0, 0, 1);
    chk("exp_pause_done", 8'(bus.done), 8'd1);
    cyc(.t(1), .c(1));       lit("alarm_clear", 7, 0, 0);

    // clear beats start in pause
    cyc(.s(1));
    cyc(.p(1));
    cyc(.s(1), .c(1));       lit("pause_clear", 7, 0, 0);

    // borrow 10 -> 09
    repeat (3) cyc(.i(1));
    cyc(.s(1));              lit("run10", 10, 1, 0);
    cyc(.t(1));              lit("borrow09", 9, 1, 0);

    // async reset in the middle of alarm
    repeat (9) cyc(.t(1));   lit("alarm_again", 0, 0, 1);
    cyc(.t(1));              lit("alarm_mid", 0, 0, 1);
    #2 reset = 1'b0;
    #1;
    lit("async_rst", 15, 0, 0);
    chk("async_rst_done", 8'(bus.done), 8'd0);
    @(negedge clock_1);
    reset = 1'b1;
    @(negedge clock_1);      lit("post_rst", 15, 0, 0);
    cyc(.s(1));              lit("post_rst_start", 15, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_timer_ctrl.md
ROUND_TIMER_CTRL -- requirements
Module: round_timer_ctrl

Interface
REQ-001 Parameter PRESET_DEFAULT, 8'h15, power-on countdown preset as two BCD digits {tens,ones}.
REQ-002 Parameter ALARM_TICKS, 3, number of tick pulses the alarm stays active after expiry (range 1..15).
REQ-003 clock_1  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-cycle pulse per countdown period (1 s), synchronous to clock_1.
REQ-006 key_start  input  1  one-cycle pulse, debounced: start or resume.
REQ-007 key_pause  input  1  one-cycle pulse: pause a running countdown.
REQ-008 key_clear  input  1  one-cycle pulse: abort to idle.
REQ-009 key_inc  input  1  one-cycle pulse: increment preset by 1 (BCD) while idle.
REQ-010 TimeH  output  4  displayed tens digit, BCD 0..9.
REQ-011 TimeL  output  4  displayed ones digit, BCD 0..9.
REQ-012 running  output  1  high only in RUN.
REQ-013 beep  output  1  high only in ALARM.
REQ-014 done  output  1  one-cycle pulse on the cycle ALARM is entered.

Function
REQ-015 States IDLE, RUN, PAUSE, ALARM; exactly one active.
REQ-016 IDLE: TimeH/TimeL show preset; key_inc adds 1 in BCD (x9 -> (x+1)0, 99 -> 00), takes effect next cycle.
REQ-017 IDLE: key_start with preset != 00 loads count <= preset and enters RUN next cycle; key_start with preset == 00 ignored.
REQ-018 RUN: TimeH/TimeL show count; each tick decrements count in BCD (x0 -> (x-1)9), one cycle latency.
REQ-019 RUN: tick with count == 01 sets count 00, enters ALARM, loads alarm counter with ALARM_TICKS, pulses done.
REQ-020 RUN: key_pause enters PAUSE; a tick in the same cycle is still applied (decrement, and expiry wins over pause if count == 01).
REQ-021 PAUSE: count held, ticks ignored; key_start returns to RUN; key_inc ignored.
REQ-022 ALARM: display 00; each tick decrements alarm counter; tick at alarm counter == 1 returns to IDLE.
REQ-023 key_clear in RUN, PAUSE or ALARM enters IDLE next cycle, count discarded, preset unchanged; key_clear has priority over all other inputs in the same cycle.
REQ-024 In a given state, keys not listed for that state are ignored; key_start in RUN and key_inc outside IDLE have no effect.
REQ-025 count never decrements below 00; TimeH/TimeL never hold a non-BCD value.
REQ-026 Outputs registered; running/beep change on the same edge as the state.

Reset
REQ-027 reset low: state IDLE, preset PRESET_DEFAULT, count PRESET_DEFAULT, alarm counter 0, TimeH/TimeL = PRESET_DEFAULT digits, running 0, beep 0, done 0.
REQ-028 reset mid-RUN/ALARM aborts immediately (asynchronously) with no done pulse; operation resumes from IDLE on the first edge after reset release.

Structure
REQ-029 Shared package holds the state encoding, the 4-bit BCD digit type and PRESET_DEFAULT.
REQ-030 One sub-module bcd2_counter: two-digit BCD register with load, increment, decrement and hold, used for both preset and count.

Verification
REQ-031 Reset, key_start, 15 ticks -> TimeH/TimeL 15,14,...,10,09,...,01,00; done pulses once at 00; beep high for exactly 3 ticks, then IDLE showing 15.
REQ-032 Idle, preset 98, key_inc x2 -> 99 then 00; key_start at 00 -> stays IDLE, running 0.
REQ-033 RUN at 07, key_pause, 5 ticks -> holds 07; key_start, 1 tick -> 06.
REQ-034 RUN at 01, tick and key_pause same cycle -> 00, ALARM, done 1; key_clear and tick same cycle in ALARM -> IDLE, beep 0.
REQ-035 RUN at 10, 1 tick -> 09 (borrow), no non-BCD value on any cycle.
REQ-036 reset asserted mid-ALARM -> beep 0, running 0 immediately, display 15, no done pulse.
